// File: rtl/quadrant_tracker_pkg.sv
// Shared definitions for the quadrant tracker.
// FSM state encoding and overflow-policy selectors.
package quadrant_tracker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int MODE_HALT = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/quadrant_tracker_p_axis_accum.sv
// One axis of the tracker: position plus displacement,
// with range detection and optional clamping.
module axis_accum #(
    parameter int DW       = 7,
    parameter int PW       = 8,
    parameter int SAT_MODE = 0
) (
    input  logic signed [PW-1:0] pos,
    input  logic signed [DW-1:0] disp,
    output logic signed [PW-1:0] next,
    output logic                 out_of_range
);
    import quadrant_tracker_pkg::*;

    localparam logic [PW-1:0] MIN_V = {1'b1, {(PW-1){1'b0}}};
    localparam logic [PW-1:0] MAX_V = {1'b0, {(PW-1){1'b1}}};

    logic [PW:0] pos_ext;
    logic [PW:0] disp_ext;
    logic [PW:0] sum;

    // One guard bit is enough: |disp| never exceeds the position range.
    always_comb begin
        pos_ext      = {pos[PW-1], pos};
        disp_ext     = {{(PW+1-DW){disp[DW-1]}}, disp};
        sum          = pos_ext + disp_ext;
        out_of_range = sum[PW] ^ sum[PW-1];
        next         = sum[PW-1:0];
        if (out_of_range && SAT_MODE == MODE_SAT) begin
            next = sum[PW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/quadrant_tracker_p.sv
// Handshaked 2-D position accumulator with quadrant output.
// Overflow either halts until reset or clamps with a sticky flag.
module quadrant_tracker_p #(
    parameter int DW       = 7,
    parameter int PW       = 8,
    parameter int SAT_MODE = 0
) (
    input  logic                 clock,
    input  logic                 reset_,
    input  logic signed [DW-1:0] dx,
    input  logic signed [DW-1:0] dy,
    input  logic                 dav_,
    output logic                 rfd,
    output logic [1:0]           q,
    output logic                 ow,
    output logic                 sat,
    output logic signed [PW-1:0] pos_x,
    output logic signed [PW-1:0] pos_y
);
    import quadrant_tracker_pkg::*;

    state_t state;

    logic signed [PW-1:0] nx;
    logic signed [PW-1:0] ny;
    logic                 ox;
    logic                 oy;
    logic                 oor;
    logic                 take;

    axis_accum #(
        .DW       (DW),
        .PW       (PW),
        .SAT_MODE (SAT_MODE)
    ) u_ax (
        .pos          (pos_x),
        .disp         (dx),
        .next         (nx),
        .out_of_range (ox)
    );

    axis_accum #(
        .DW       (DW),
        .PW       (PW),
        .SAT_MODE (SAT_MODE)
    ) u_ay (
        .pos          (pos_y),
        .disp         (dy),
        .next         (ny),
        .out_of_range (oy)
    );

    // In clamp mode an overflowing command is still applied.
    always_comb begin
        oor  = ox | oy;
        take = !oor || (SAT_MODE == MODE_SAT);
    end

    // Handshake FSM with registered position, quadrant and flags.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= S_IDLE;
            rfd   <= 1'b1;
            q     <= 2'b00;
            ow    <= 1'b0;
            sat   <= 1'b0;
            pos_x <= '0;
            pos_y <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!dav_) begin
                        rfd <= 1'b0;
                        if (take) begin
                            pos_x <= nx;
                            pos_y <= ny;
                            q     <= {nx[PW-1], ny[PW-1]};
                            state <= S_ACK;
                            if (oor) begin
                                sat <= 1'b1;
                            end
                        end else begin
                            ow    <= 1'b1;
                            state <= S_HALT;
                        end
                    end
                end
                S_ACK: begin
                    if (dav_) begin
                        rfd   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    rfd <= 1'b0;
                    ow  <= 1'b1;
                end
                default: begin
                    rfd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/quadrant_tracker_p.md
Name: quadrant_tracker_p

Overview:
- Parametrised successor to the 2-D position/quadrant tracker.
- Accumulates signed displacements (dx, dy) received over a dav_/rfd handshake into signed X/Y position registers.
- Outputs the current quadrant and the full position.
- Overflow policy is selectable: halt until reset (legacy behaviour) or saturate and continue with a sticky flag.
- Sits between a displacement producer (pointing device / motion decoder) and downstream logic that consumes quadrant or position.

Parameters:
- DW, 7, displacement width (two's complement); requires DW <= PW.
- PW, 8, position register width (two's complement).
- SAT_MODE, 0, overflow policy: 0 = halt until reset; 1 = clamp to range and continue.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_  in  1  synchronous, active-low reset, sampled at posedge clock.
- dx  in  DW  signed X displacement; valid while dav_=0.
- dy  in  DW  signed Y displacement; valid while dav_=0.
- dav_  in  1  data-available strobe, active low.
- rfd  out  1  ready-for-data, active high.
- q  out  2  quadrant: q[1] = sign(X), q[0] = sign(Y).
- ow  out  1  overflow; halt mode only, otherwise always 0.
- sat  out  1  sticky saturation flag; SAT_MODE=1 only, otherwise always 0.
- pos_x  out  PW  current X position, signed.
- pos_y  out  PW  current Y position, signed.

Behaviour:
- Reset (reset_=0 at posedge, any state): X=Y=0, q=00, ow=0, sat=0, rfd=1, state=S_IDLE. Reset mid-handshake or in S_HALT discards all state.
- S_IDLE (rfd=1):
  - At a posedge with dav_=0: compute Xn = X + sext(dx) and Yn = Y + sext(dy), both in PW+1 bits.
  - Same edge: rfd<=0.
- Range per axis: MIN = -2^(PW-1), MAX = 2^(PW-1)-1.
- Update, no axis out of range: X<=Xn, Y<=Yn, q<={Xn sign, Yn sign}; next state S_ACK.
- Update, any axis out of range, SAT_MODE=0:
  - X, Y, q hold their pre-command values; ow<=1; next state S_HALT.
- Update, any axis out of range, SAT_MODE=1:
  - Each out-of-range axis is clamped to MIN/MAX; the other axis updates normally.
  - q is taken from the clamped values; sat<=1 (sticky until reset); next state S_ACK.
- Update latency: q/pos valid one clock after the dav_ sampling edge, coincident with rfd falling.
- S_ACK (rfd=0): at a posedge with dav_=1, rfd<=1 and go to S_IDLE. dx/dy are ignored in this state.
- S_HALT: rfd=0, ow=1; all inputs except reset_ are ignored. The only exit is reset.
- dav_ held low across S_ACK keeps the block in S_ACK. Each command needs one full dav_ low→high cycle; there are no back-to-back double counts.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package quadrant_tracker_pkg holds:
  - state encoding S_IDLE, S_ACK, S_HALT (2-bit);
  - SAT_MODE constants MODE_HALT=0, MODE_SAT=1.
- Sub-module axis_accum, instantiated twice (X, Y):
  - parametrised DW, PW, SAT_MODE;
  - inputs: current position, displacement;
  - outputs: next value (clamped when SAT_MODE=1) and out_of_range.
- Top level holds the FSM, registers and the rfd/ow/sat logic.

Test Plan (defaults DW=7, PW=8 unless noted):
- Reset, then the sequence (-32,0), (0,-32), (+63,0), (0,+63), (-64,0) -> q = 10, 11, 01, 00, 10; pos ends (-33,31); rfd pulses low then high per command; ow=0.
- SAT_MODE=0: after reset, issue (-64,0) three times -> pos_x = -64, then -128 with q=10; third command gives ow=1, rfd stuck at 0, pos_x stays -128; further dav_ pulses are ignored; reset_ -> q=00, ow=0, rfd=1.
- SAT_MODE=1: same three commands -> third command gives pos_x=-128, sat=1, q=10, rfd returns to 1; a following (+63,+63) gives pos=(-65,63), q=10, sat stays 1.
- Both axes overflow together, SAT_MODE=1: reach (127,127) with (+63,+63), (+63,+63), (+1,+1), then apply (+1,+1) -> pos=(127,127), q=00, sat=1.
- dav_ held low for 5 clocks -> exactly one update, rfd stays 0 until dav_=1, then rises on the next posedge.
- Reset asserted in S_ACK with dav_=0 -> next posedge: rfd=1, pos=(0,0); releasing reset with dav_ still low starts a new command.
- Parametrised instance DW=4, PW=6: (-8,0) four times -> pos_x = -8, -16, -24, -32; the fifth command gives ow=1 (SAT_MODE=0).
